// File: rtl/vector_add_sequencer.sv
// Batch engine: reads ROM and RAM0 over an address window and writes each
// element sum into RAM1, with a running checksum and overflow count.
module vector_add_sequencer #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W:0]          length,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rom_data,
  input  logic [DATA_W-1:0]        ram0_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W:0]          wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [DATA_W+ADDR_W+1:0] checksum,
  output logic [ADDR_W:0]          ovf_count
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned SUM_W = DATA_W + 1;
  localparam int unsigned CHK_W = DATA_W + ADDR_W + 2;
  localparam int unsigned VLD_W = RD_LAT + 1;
  localparam int unsigned APW   = ADDR_W * RD_LAT;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(1) << ADDR_W;

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [VLD_W-1:0]  vld_q, vld_d;
  logic [APW-1:0]    apipe_q, apipe_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [SUM_W-1:0]  wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [CHK_W-1:0]  checksum_q, checksum_d;
  logic [LEN_W-1:0]  ovf_q, ovf_d;

  logic [LEN_W-1:0]  len_clamped;
  logic [SUM_W-1:0]  sum;
  logic              emerge;
  logic              cancel;

  assign len_clamped = (length > FULL_LEN) ? FULL_LEN : length;
  assign sum         = SUM_W'(rom_data) + SUM_W'(ram0_data);
  assign emerge      = vld_q[RD_LAT];
  assign cancel      = abort && ((state_q == S_RUN) || (state_q == S_DRAIN));

  // Next-state, read issue and write-back datapath
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rd_addr_d  = rd_addr_q;
    vld_d      = VLD_W'({vld_q, 1'b0});
    apipe_d    = APW'({apipe_q, rd_addr_q});
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    aborted_d  = aborted_q;
    checksum_d = checksum_q;
    ovf_d      = ovf_q;

    if (emerge && !cancel) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = apipe_q[APW-1 -: ADDR_W];
      wr_data_d  = sum;
      checksum_d = checksum_q + CHK_W'(sum);
      ovf_d      = ovf_q + LEN_W'(sum[DATA_W]);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = len_clamped;
          cnt_d      = LEN_W'(1);
          checksum_d = '0;
          ovf_d      = '0;
          aborted_d  = 1'b0;
          if (len_clamped == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_RUN;
            busy_d    = 1'b1;
            rd_addr_d = base_addr;
            vld_d[0]  = 1'b1;
          end
        end
      end
      S_RUN, S_DRAIN: begin
        if (cancel) begin
          // In-flight reads are dropped; completed writes stand
          state_d   = S_DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          busy_d    = 1'b0;
          vld_d     = '0;
        end else if (state_q == S_RUN) begin
          if (cnt_q == len_q) begin
            state_d = S_DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            cnt_d     = cnt_q + LEN_W'(1);
            vld_d[0]  = 1'b1;
          end
        end else if (vld_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      vld_q      <= '0;
      apipe_q    <= '0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      checksum_q <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
      apipe_q    <= apipe_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      checksum_q <= checksum_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign checksum  = checksum_q;
  assign ovf_count = ovf_q;

endmodule

// File: tb/tb_vector_add_sequencer.sv
// Directed bench: three sequencers (read latency 1, 2, 3) share stimulus,
// each fed by its own latency-matched ROM/RAM0 model.
module tb_vector_add_sequencer;

  logic        clk;
  logic        reset_n, start, abort;
  logic [9:0]  base_addr;
  logic [10:0] length;
  int          mode;
  int          checks, errors;

  logic [9:0]  rd_addr_a [3];
  logic        wr_en_a   [3];
  logic [9:0]  wr_addr_a [3];
  logic [4:0]  wr_data_a [3];
  logic        busy_a    [3];
  logic        done_a    [3];
  logic        aborted_a [3];
  logic [15:0] cks_a     [3];
  logic [10:0] ovf_a     [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents per scenario
  function automatic logic [3:0] rom_f(input logic [9:0] a);
    return (mode == 1) ? 4'hF : a[3:0];
  endfunction

  function automatic logic [3:0] ram_f(input logic [9:0] a);
    if (mode == 1) return 4'h1;
    if (mode == 2) return a[7:4];
    return 4'h0;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = g + 1;
    localparam int unsigned PW  = 4 * LAT;
    logic [PW-1:0] rom_p, ram_p;

    always_ff @(posedge clk) begin
      rom_p <= PW'({rom_p, rom_f(rd_addr_a[g])});
      ram_p <= PW'({ram_p, ram_f(rd_addr_a[g])});
    end

    vector_add_sequencer #(.ADDR_W(10), .DATA_W(4), .RD_LAT(LAT)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .base_addr (base_addr),
      .length    (length),
      .rd_addr   (rd_addr_a[g]),
      .rom_data  (rom_p[PW-1 -: 4]),
      .ram0_data (ram_p[PW-1 -: 4]),
      .wr_en     (wr_en_a[g]),
      .wr_addr   (wr_addr_a[g]),
      .wr_data   (wr_data_a[g]),
      .busy      (busy_a[g]),
      .done      (done_a[g]),
      .aborted   (aborted_a[g]),
      .checksum  (cks_a[g]),
      .ovf_count (ovf_a[g])
    );
  end

  function automatic logic [55:0] outs(input int i);
    return {rd_addr_a[i], wr_en_a[i], wr_addr_a[i], wr_data_a[i], busy_a[i],
            done_a[i], aborted_a[i], cks_a[i], ovf_a[i]};
  endfunction

  // Called at a negedge; returns at the negedge of cycle S+1
  task automatic launch(input logic [9:0] b, input logic [10:0] l);
    start = 1'b1; base_addr = b; length = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (outs(i) !== 56'h0) begin errors++; $display("FAIL reset_hold dut%0d got %h exp 0", i, outs(i)); end
      checks++;
    end
    reset_n = 1'b1;
    @(negedge clk);
    mode = 0;
    launch(10'd0, 11'd8);
    repeat (3) @(negedge clk);
    if (wr_en_a[0] !== 1'b1) begin errors++; $display("FAIL reset_pre wr_en got %b exp 1", wr_en_a[0]); end
    checks++;
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (outs(i) !== 56'h0) begin errors++; $display("FAIL reset_async dut%0d got %h exp 0", i, outs(i)); end
      checks++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if ({wr_en_a[i], done_a[i], busy_a[i]} !== 3'b000) begin
          errors++; $display("FAIL reset_after dut%0d we/done/busy got %b exp 000", i, {wr_en_a[i], done_a[i], busy_a[i]});
        end
        checks++;
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    logic ew, ed, eb;
    mode = 0;
    repeat (2) @(negedge clk);
    launch(10'd0, 11'd4);
    for (int c = 1; c <= 12; c++) begin
      for (int i = 0; i < 3; i++) begin
        lat = i + 1;
        ew = (c >= 2 + lat) && (c <= 5 + lat);
        ed = (c == 6 + lat);
        eb = (c <= 5 + lat);
        if ({wr_en_a[i], done_a[i], busy_a[i]} !== {ew, ed, eb}) begin
          errors++; $display("FAIL basic_ctl dut%0d c%0d got %b exp %b", i, c, {wr_en_a[i], done_a[i], busy_a[i]}, {ew, ed, eb});
        end
        checks++;
        if (ew) begin
          if ({wr_addr_a[i], wr_data_a[i]} !== {10'(c - 2 - lat), 5'(c - 2 - lat)}) begin
            errors++; $display("FAIL basic_wr dut%0d c%0d got %0d/%0d exp %0d", i, c, wr_addr_a[i], wr_data_a[i], c - 2 - lat);
          end
          checks++;
        end
        if (ed) begin
          if ({cks_a[i], ovf_a[i], aborted_a[i]} !== {16'd6, 11'd0, 1'b0}) begin
            errors++; $display("FAIL basic_sum dut%0d got cks %0d ovf %0d ab %b exp 6 0 0", i, cks_a[i], ovf_a[i], aborted_a[i]);
          end
          checks++;
        end
      end
      if (c <= 4 || c == 7) begin
        if (rd_addr_a[0] !== 10'((c <= 4) ? c - 1 : 3)) begin
          errors++; $display("FAIL basic_rd c%0d got %0d exp %0d", c, rd_addr_a[0], (c <= 4) ? c - 1 : 3);
        end
        checks++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    int n;
    logic got;
    n = 0; got = 1'b0;
    mode = 1;
    repeat (2) @(negedge clk);
    launch(10'd1022, 11'd4);
    for (int c = 1; c <= 12; c++) begin
      if (wr_en_a[0]) begin
        if ({wr_addr_a[0], wr_data_a[0]} !== {10'(1022 + n), 5'h10}) begin
          errors++; $display("FAIL wrap_wr n%0d got %0d/%h exp %0d/10", n, wr_addr_a[0], wr_data_a[0], 10'(1022 + n));
        end
        checks++;
        n++;
      end
      if (done_a[0]) begin
        got = 1'b1;
        if ({cks_a[0], ovf_a[0]} !== {16'd64, 11'd4}) begin
          errors++; $display("FAIL wrap_sum got cks %0d ovf %0d exp 64 4", cks_a[0], ovf_a[0]);
        end
        checks++;
      end
      @(negedge clk);
    end
    if (!got || n != 4) begin errors++; $display("FAIL wrap_count got done %b writes %0d exp 1 4", got, n); end
    checks++;
  endtask

  task automatic test_zero_len();
    mode = 0;
    repeat (2) @(negedge clk);
    launch(10'd3, 11'd0);
    if ({done_a[0], busy_a[0], wr_en_a[0], cks_a[0], ovf_a[0]} !== {3'b100, 16'd0, 11'd0}) begin
      errors++; $display("FAIL zero_done got d%b b%b w%b cks %0d ovf %0d exp 1 0 0 0 0",
                         done_a[0], busy_a[0], wr_en_a[0], cks_a[0], ovf_a[0]);
    end
    checks++;
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      if ({busy_a[0], done_a[0], wr_en_a[0]} !== 3'b000) begin
        errors++; $display("FAIL zero_idle c%0d got %b exp 000", c, {busy_a[0], done_a[0], wr_en_a[0]});
      end
      checks++;
    end
  endtask

  task automatic test_full();
    int n;
    logic got;
    n = 0; got = 1'b0;
    mode = 2;
    repeat (2) @(negedge clk);
    launch(10'd5, 11'd2047);
    for (int c = 1; c <= 1100 && !got; c++) begin
      if (wr_en_a[0]) begin
        if (wr_addr_a[0] !== 10'(5 + n)) begin
          errors++; $display("FAIL full_addr n%0d got %0d exp %0d", n, wr_addr_a[0], 10'(5 + n));
        end
        checks++;
        n++;
      end
      if (done_a[0]) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin errors++; $display("FAIL full_timeout got no done exp done within 1100 cycles"); end
    checks++;
    if ({n[10:0], cks_a[0], ovf_a[0]} !== {11'd1024, 16'd15360, 11'd480}) begin
      errors++; $display("FAIL full_sum got writes %0d cks %0d ovf %0d exp 1024 15360 480", n, cks_a[0], ovf_a[0]);
    end
    checks++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort();
    mode = 0;
    repeat (2) @(negedge clk);
    launch(10'd100, 11'd8);
    for (int c = 1; c <= 2; c++) begin
      if (wr_en_a[0] !== 1'b0) begin errors++; $display("FAIL abort_early c%0d got %b exp 0", c, wr_en_a[0]); end
      checks++;
      @(negedge clk);
    end
    if ({wr_en_a[0], wr_addr_a[0], wr_data_a[0]} !== {1'b1, 10'd100, 5'd4}) begin
      errors++; $display("FAIL abort_wr got %b/%0d/%0d exp 1/100/4", wr_en_a[0], wr_addr_a[0], wr_data_a[0]);
    end
    checks++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    if ({done_a[0], aborted_a[0], wr_en_a[0], busy_a[0]} !== 4'b1100) begin
      errors++; $display("FAIL abort_done got %b exp 1100", {done_a[0], aborted_a[0], wr_en_a[0], busy_a[0]});
    end
    checks++;
    for (int c = 5; c <= 9; c++) begin
      @(negedge clk);
      if ({wr_en_a[0], done_a[0], busy_a[0], aborted_a[0]} !== 4'b0001) begin
        errors++; $display("FAIL abort_after c%0d got %b exp 0001", c, {wr_en_a[0], done_a[0], busy_a[0], aborted_a[0]});
      end
      checks++;
    end
    if ({cks_a[0], ovf_a[0]} !== {16'd4, 11'd0}) begin
      errors++; $display("FAIL abort_sum got cks %0d ovf %0d exp 4 0", cks_a[0], ovf_a[0]);
    end
    checks++;
  endtask

  task automatic test_abort_idle();
    mode = 0;
    abort = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if ({busy_a[0], done_a[0], aborted_a[0]} !== 3'b001) begin
        errors++; $display("FAIL abort_idle got %b exp 001", {busy_a[0], done_a[0], aborted_a[0]});
      end
      checks++;
    end
    launch(10'd0, 11'd4);
    abort = 1'b0;
    if ({busy_a[0], aborted_a[0]} !== 2'b10) begin
      errors++; $display("FAIL abort_start_wins got busy %b ab %b exp 1 0", busy_a[0], aborted_a[0]);
    end
    checks++;
    repeat (6) @(negedge clk);
    if ({done_a[0], aborted_a[0], cks_a[0]} !== {2'b10, 16'd6}) begin
      errors++; $display("FAIL abort_start_done got d%b ab%b cks %0d exp 1 0 6", done_a[0], aborted_a[0], cks_a[0]);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic eb, ed;
    repeat (4) @(negedge clk);
    start = 1'b1; base_addr = 10'd0; length = 11'd2;
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      eb = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
      ed = (c == 5) || (c == 11);
      if ({busy_a[0], done_a[0]} !== {eb, ed}) begin
        errors++; $display("FAIL b2b c%0d busy/done got %b exp %b", c, {busy_a[0], done_a[0]}, {eb, ed});
      end
      checks++;
      if (c == 7) begin
        if (rd_addr_a[0] !== 10'd0) begin errors++; $display("FAIL b2b_rd got %0d exp 0", rd_addr_a[0]); end
        checks++;
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore();
    int n;
    n = 0;
    mode = 0;
    repeat (4) @(negedge clk);
    launch(10'd0, 11'd4);
    for (int c = 1; c <= 14; c++) begin
      if (wr_en_a[0]) begin
        if (wr_addr_a[0] !== 10'(n)) begin errors++; $display("FAIL ign_addr n%0d got %0d exp %0d", n, wr_addr_a[0], n); end
        checks++;
        n++;
      end
      if ({busy_a[0], done_a[0]} !== {c <= 6, c == 7}) begin
        errors++; $display("FAIL ign_ctl c%0d got %b exp %b", c, {busy_a[0], done_a[0]}, {c <= 6, c == 7});
      end
      checks++;
      if (c == 2 || c == 7) begin start = 1'b1; base_addr = (c == 2) ? 10'd500 : 10'd600; end
      if (c == 3 || c == 8) start = 1'b0;
      @(negedge clk);
    end
    if (n != 4) begin errors++; $display("FAIL ign_count got %0d exp 4", n); end
    checks++;
  endtask

  initial begin
    checks = 0; errors = 0; mode = 0;
    reset_n = 1'b1; start = 1'b0; abort = 1'b0;
    base_addr = '0; length = '0;
    #2 reset_n = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_full();
    test_abort();
    test_abort_idle();
    test_back_to_back();
    test_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
